// File: rtl/qspi_request_arbiter.sv
// qspi_request_arbiter: round-robin front end that shares one QSPI controller
// between NREQ requesters. A winner's descriptor is latched, the controller's
// two config registers are written, start is pulsed, busy is supervised, and
// the winner's TX/RX streams are routed until done.
//
// Stream handshakes (valid/ready): a word moves on a rising clk edge when both
// valid and ready are high. valid must not depend on ready. Only the granted
// requester sees the controller's ready/valid, and only while in XFER.
module qspi_request_arbiter #(
    parameter int NREQ           = 4,
    parameter int DATA_BITS      = 32,
    parameter int SHIFT_REG_BITS = 32,
    parameter int DIVIDER_WIDTH  = 16,
    parameter int NSLAVE         = 4,
    parameter int START_TIMEOUT  = 16,
    localparam int SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1,
    localparam int MW = 2 + DIVIDER_WIDTH + SW,
    localparam int GW = $clog2(NREQ),
    localparam int TW = $clog2(START_TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*MW-1:0]           req_mode,
    input  logic [NREQ*SHIFT_REG_BITS-1:0] req_cfg0,
    input  logic [NREQ*SHIFT_REG_BITS-1:0] req_cfg1,
    input  logic [NREQ*DATA_BITS-1:0]    req_tx_data,
    input  logic [NREQ-1:0]              req_tx_valid,
    output logic [NREQ-1:0]              req_tx_ready,
    output logic [DATA_BITS-1:0]         req_rx_data,
    output logic [NREQ-1:0]              req_rx_valid,
    input  logic [NREQ-1:0]              req_rx_ready,
    output logic [NREQ-1:0]              gnt,
    output logic [NREQ-1:0]              req_done,
    output logic [NREQ-1:0]              req_err,
    output logic                         ctl_start,
    output logic                         ctl_cpol,
    output logic                         ctl_cpha,
    output logic [DIVIDER_WIDTH-1:0]     ctl_dvsr,
    output logic [SW-1:0]                ctl_cs_num,
    output logic                         ctl_config_addr,
    output logic                         ctl_config_write,
    output logic [SHIFT_REG_BITS-1:0]    ctl_config_data,
    output logic [DATA_BITS-1:0]         ctl_tx_data,
    output logic                         ctl_tx_valid,
    input  logic                         ctl_tx_ready,
    input  logic [DATA_BITS-1:0]         ctl_rx_data,
    input  logic                         ctl_data_valid,
    output logic                         ctl_data_ready,
    input  logic                         ctl_busy,
    input  logic                         ctl_done,
    output logic [2:0]                   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CFG0      = 3'd1,
        S_CFG1      = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_XFER      = 3'd5,
        S_RELEASE   = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_timeout;
    logic                      w_any;
    logic [GW-1:0]             w_win;
    logic [GW-1:0]             w_idx;
    logic [NREQ-1:0]           w_win_oh;
    logic [NREQ-1:0]           w_g_oh;
    logic [GW-1:0]             r_ptr;
    logic [GW-1:0]             r_g;
    logic [MW-1:0]             r_mode;
    logic [SHIFT_REG_BITS-1:0] r_cfg1;
    logic [TW-1:0]             r_cnt;
    logic [NREQ-1:0]           r_gnt;
    logic [NREQ-1:0]           r_done;
    logic [NREQ-1:0]           r_err;
    logic                      r_start;
    logic                      r_cfg_write;
    logic                      r_cfg_addr;
    logic [SHIFT_REG_BITS-1:0] r_cfg_data;

    assign w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_g_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_g;

    // Round-robin pick: scan downwards so the requester closest to ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = GW'((int'(r_ptr) + k) % NREQ);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Next-state logic; done in WAIT_BUSY is a short transfer and beats busy/timeout.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:      if (w_any) w_next = S_CFG0;
            S_CFG0:      w_next = S_CFG1;
            S_CFG1:      w_next = S_START;
            S_START:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (ctl_done) begin
                    w_next = S_RELEASE;
                end else if (ctl_busy) begin
                    w_next = S_XFER;
                end else if (r_cnt == TW'(START_TIMEOUT - 1)) begin
                    w_next    = S_RELEASE;
                    w_timeout = 1'b1;
                end
            end
            S_XFER:      if (ctl_done) w_next = S_RELEASE;
            S_RELEASE:   w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // State, pointer, latched descriptor and start-timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
            r_mode  <= '0;
            r_cfg1  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_any) begin
                r_g    <= w_win;
                r_mode <= req_mode[int'(w_win)*MW +: MW];
                r_cfg1 <= req_cfg1[int'(w_win)*SHIFT_REG_BITS +: SHIFT_REG_BITS];
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_RELEASE) begin
                r_ptr <= (r_g == GW'(NREQ - 1)) ? '0 : r_g + 1'b1;
            end
        end
    end

    // Registered control outputs, computed from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_start     <= 1'b0;
            r_cfg_write <= 1'b0;
            r_cfg_addr  <= 1'b0;
            r_cfg_data  <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_gnt <= w_win_oh;
            end else if (r_state == S_RELEASE) begin
                r_gnt <= '0;
            end
            r_done      <= (w_next == S_RELEASE) ? w_g_oh : '0;
            r_err       <= (w_next == S_RELEASE && w_timeout) ? w_g_oh : '0;
            r_start     <= (w_next == S_START);
            r_cfg_write <= (w_next == S_CFG0) || (w_next == S_CFG1);
            r_cfg_addr  <= (w_next == S_CFG1);
            if (w_next == S_CFG0) begin
                r_cfg_data <= req_cfg0[int'(w_win)*SHIFT_REG_BITS +: SHIFT_REG_BITS];
            end else if (w_next == S_CFG1) begin
                r_cfg_data <= r_cfg1;
            end else begin
                r_cfg_data <= '0;
            end
        end
    end

    // Stream routing for the granted requester, open only during XFER.
    always_comb begin
        ctl_tx_data    = '0;
        ctl_tx_valid   = 1'b0;
        req_tx_ready   = '0;
        req_rx_valid   = '0;
        ctl_data_ready = 1'b0;
        if (r_state == S_XFER) begin
            ctl_tx_data         = req_tx_data[int'(r_g)*DATA_BITS +: DATA_BITS];
            ctl_tx_valid        = req_tx_valid[r_g];
            req_tx_ready[r_g]   = ctl_tx_ready;
            req_rx_valid[r_g]   = ctl_data_valid;
            ctl_data_ready      = req_rx_ready[r_g];
        end
    end

    assign req_rx_data      = ctl_rx_data;
    assign gnt              = r_gnt;
    assign req_done         = r_done;
    assign req_err          = r_err;
    assign ctl_start        = r_start;
    assign ctl_config_write = r_cfg_write;
    assign ctl_config_addr  = r_cfg_addr;
    assign ctl_config_data  = r_cfg_data;
    assign ctl_cpol         = r_mode[MW-1];
    assign ctl_cpha         = r_mode[MW-2];
    assign ctl_dvsr         = r_mode[SW +: DIVIDER_WIDTH];
    assign ctl_cs_num       = r_mode[SW-1:0];
    assign dbg_state        = r_state;

endmodule
